fdd_motor_ctrl: RTL and testbench
=================================

Name: fdd_motor_ctrl

Overview:
- Drive-side motor timing model for the MSX floppy subsystem. Feeds the per-drive `motor_run` bits consumed by the FDD ready/status logic.
- Takes per-drive motor-on requests from the disk interface and models a spin-up delay before a motor counts as running. After a request drops, it keeps the motor running for a hold timeout.
- Generates the index pulse (`INDEXn`) for the selected drive while that drive is running with a disk present.

Parameters:
- CLK_KHZ, 21477, clk cycles per 1 ms tick (minimum 1)
- DELAY_MS, 300, spin-up time in ms ticks (0 = run on the next cycle)
- TIMEOUT_MS, 3000, motor hold time in ms ticks after the request drops (minimum 1)
- ROT_MS, 200, index period in ms ticks, one revolution (minimum 2)
- INDEX_MS, 4, index low width in ms ticks (1 .. ROT_MS-1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- motor_on  in  4  per-drive motor request, level
- USEL  in  2  selected drive
- disk_present  in  4  per-drive image mounted and valid
- motor_run  out  4  per-drive motor at speed
- INDEXn  out  1  index pulse of the selected drive, active low

Behaviour:
- Reset is sampled on posedge clk; reset=0 wins over all other inputs.
  - Reset values: all drive FSMs in OFF, all counters 0, prescaler 0.
  - Reset outputs: motor_run=4'b0000, INDEXn=1.
- Prescaler: counts 0..CLK_KHZ-1 and wraps. `tick` is a one-cycle strobe when the count equals CLK_KHZ-1. It is free-running, not restarted by requests.
- Per-drive FSM (four independent instances). Each has a ms counter cnt, width $clog2(max(DELAY_MS,TIMEOUT_MS)+1).
  - OFF: motor_on=1 -> SPINUP, cnt=0. If DELAY_MS=0 -> RUN directly.
  - SPINUP:
    - motor_on=0 -> OFF, cnt=0. This has priority over a simultaneous tick.
    - On tick: if cnt+1==DELAY_MS -> RUN, else cnt++.
  - RUN: motor_on=0 -> HOLD, cnt=0.
  - HOLD:
    - motor_on=1 -> RUN. This has priority over a simultaneous expiring tick.
    - On tick: if cnt+1==TIMEOUT_MS -> OFF, else cnt++.
  - motor_run[i] = 1 when the state register is RUN or HOLD. It is a combinational decode of the registered state, so there is no extra latency.
- Index generator: single rotation counter rc, width $clog2(ROT_MS).
  - Active when motor_run[USEL] && disk_present[USEL].
  - When inactive: rc=0, INDEXn=1.
  - When active: on tick, rc wraps at ROT_MS-1, else rc++.
  - INDEXn is registered: INDEXn <= !(active && rc < INDEX_MS). The first revolution therefore starts with the index low.
  - A USEL change clears rc and drives INDEXn=1 for one cycle, then restarts a revolution.
- Drives never interact. Any motor_on combination, including all four at once, is legal.
- A reset in any state returns to OFF on the next edge. No motor_run glitch high is allowed.

Test Plan:
- Bench parameters for all scenarios: CLK_KHZ=4, DELAY_MS=3, TIMEOUT_MS=5, ROT_MS=10, INDEX_MS=2.
- Reset: hold reset=0 with motor_on=4'hF for 20 cycles -> motor_run=0, INDEXn=1 throughout. Release reset -> motor_run[3:0] rises together on the cycle after the 3rd tick.
- Spin-up:
  - motor_on[0]=1 held -> motor_run[0]=0 through two ticks, =1 on the cycle after the 3rd tick.
  - Drop motor_on[0] after the 2nd tick -> motor_run[0] never rises. Reassert -> a full 3 ticks are needed again.
- Hold:
  - With drive 1 running, drop motor_on[1] -> motor_run[1] stays 1 for 5 ticks and clears on the cycle after the 5th.
  - Reassert at the 4th tick -> stays 1. A later drop needs a full 5 ticks again.
  - A drop and reassert in the same cycle as an expiring tick -> stays 1.
- Index:
  - USEL=0, drive 0 running, disk_present[0]=1 -> INDEXn low for 8 clocks, high for 32 clocks, repeating with a 40-clock period.
  - disk_present[0]=0 -> INDEXn=1 constantly.
  - Switch USEL to an OFF drive -> INDEXn=1.
- Independence/reset mid-operation:
  - Drives 0 and 2 staggered by 1 tick -> each motor_run edge is offset by exactly 4 clocks.
  - Assert reset=0 mid-SPINUP of drive 3 -> motor_run=0 on the next edge and no later spurious rise.

Source files
------------

// File: rtl/fdd_motor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fdd_motor_ctrl
//  Description : Drive-side motor timing model for the MSX floppy subsystem.
//                Four independent per-drive FSMs model spin-up delay and a
//                post-request hold time. A shared rotation counter generates
//                the active-low index pulse for the selected drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module fdd_motor_ctrl #(
   parameter int CLK_KHZ    = 21477,  // clk cycles per 1 ms tick
   parameter int DELAY_MS   = 300,    // spin-up time in ms ticks
   parameter int TIMEOUT_MS = 3000,   // hold time after request drops
   parameter int ROT_MS     = 200,    // one revolution in ms ticks
   parameter int INDEX_MS   = 4       // index low width in ms ticks
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] motor_on,
   input  logic [1:0] USEL,
   input  logic [3:0] disk_present,
   output logic [3:0] motor_run,
   output logic       INDEXn
);

   // Prescaler width; a one-cycle tick period still needs a 1-bit register.
   localparam int c_PW      = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
   localparam int c_CNT_MAX = (DELAY_MS > TIMEOUT_MS) ? DELAY_MS : TIMEOUT_MS;
   localparam int c_CW      = (c_CNT_MAX > 0) ? $clog2(c_CNT_MAX + 1) : 1;
   localparam int c_RW      = $clog2(ROT_MS);

   localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(CLK_KHZ - 1);
   localparam logic [c_CW-1:0] c_DELAY      = c_CW'(DELAY_MS);
   localparam logic [c_CW-1:0] c_TIMEOUT    = c_CW'(TIMEOUT_MS);
   localparam logic [c_RW-1:0] c_ROT_LAST   = c_RW'(ROT_MS - 1);
   localparam logic [c_RW-1:0] c_INDEX_W    = c_RW'(INDEX_MS);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SPINUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_HOLD   = 2'd3
   } drv_state_t;

   logic [c_PW-1:0] r_presc;
   logic            w_tick;
   logic [c_RW-1:0] r_rc;
   logic            r_indexn;
   logic [1:0]      r_usel;
   logic            w_active;
   logic            w_usel_chg;

   assign w_tick = (r_presc == c_PRESC_LAST);

   // Free-running ms prescaler; never restarted by drive activity.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + c_PW'(1);
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_drive
      drv_state_t      r_state;
      drv_state_t      w_state_nxt;
      logic [c_CW-1:0] r_cnt;
      logic [c_CW-1:0] w_cnt_nxt;
      logic [c_CW-1:0] w_cnt_inc;

      assign w_cnt_inc = r_cnt + c_CW'(1);

      // Per-drive state and ms counter register.
      always_ff @(posedge clk) begin
         if (!reset) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      // Next-state logic: request level beats a coincident tick in SPINUP/HOLD.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         case (r_state)
            ST_OFF: begin
               if (motor_on[gi]) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = (DELAY_MS == 0) ? ST_RUN : ST_SPINUP;
               end
            end
            ST_SPINUP: begin
               if (!motor_on[gi]) begin
                  w_state_nxt = ST_OFF;
                  w_cnt_nxt   = '0;
               end else if (w_tick) begin
                  if (w_cnt_inc == c_DELAY) begin
                     w_state_nxt = ST_RUN;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end
            end
            ST_RUN: begin
               if (!motor_on[gi]) begin
                  w_state_nxt = ST_HOLD;
                  w_cnt_nxt   = '0;
               end
            end
            ST_HOLD: begin
               if (motor_on[gi]) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else if (w_tick) begin
                  if (w_cnt_inc == c_TIMEOUT) begin
                     w_state_nxt = ST_OFF;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_OFF;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // Running covers the hold period as well; decoded straight off the register.
      assign motor_run[gi] = (r_state == ST_RUN) || (r_state == ST_HOLD);
   end

   assign w_active   = motor_run[USEL] & disk_present[USEL];
   assign w_usel_chg = (USEL != r_usel);

   // Rotation counter and registered index pulse; a drive switch restarts the revolution.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rc     <= '0;
         r_indexn <= 1'b1;
         r_usel   <= 2'd0;
      end else begin
         r_usel <= USEL;
         if (w_usel_chg || !w_active) begin
            r_rc     <= '0;
            r_indexn <= 1'b1;
         end else begin
            r_indexn <= !(r_rc < c_INDEX_W);
            if (w_tick) begin
               r_rc <= (r_rc == c_ROT_LAST) ? '0 : r_rc + c_RW'(1);
            end
         end
      end
   end

   assign INDEXn = r_indexn;

endmodule
`default_nettype wire

// File: tb/tb_fdd_motor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdd_motor_ctrl
//  Description : Self-checking bench for fdd_motor_ctrl with small timing
//                parameters (4 clk per tick, 3-tick spin-up, 5-tick hold,
//                10-tick revolution, 2-tick index). Each scenario begins with
//                a one-cycle reset so the free-running prescaler is realigned
//                and ticks land on edges 4, 8, 12, ... after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fdd_motor_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] motor_on;
   logic [1:0] USEL;
   logic [3:0] disk_present;
   logic [3:0] motor_run;
   logic       INDEXn;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic       rst_n;
      logic [3:0] mon;
      logic [1:0] usel;
      logic [3:0] dp;
      logic [3:0] exp_run;
      logic       exp_idx;
      int         scen;
   } vec_t;

   vec_t vecs[$];

   fdd_motor_ctrl #(
      .CLK_KHZ   (4),
      .DELAY_MS  (3),
      .TIMEOUT_MS(5),
      .ROT_MS    (10),
      .INDEX_MS  (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .motor_on    (motor_on),
      .USEL        (USEL),
      .disk_present(disk_present),
      .motor_run   (motor_run),
      .INDEXn      (INDEXn)
   );

   always #5 clk = ~clk;

   function automatic string scen_name(input int s);
      case (s)
         0: return "reset";
         1: return "spinup";
         2: return "spinup_abort";
         3: return "hold";
         4: return "hold_reassert";
         5: return "hold_expire_race";
         6: return "index";
         7: return "stagger";
         8: return "reset_mid_spinup";
         default: return "unknown";
      endcase
   endfunction

   function automatic void add(input int n, input logic r, input logic [3:0] mon,
                               input logic [1:0] us, input logic [3:0] dp,
                               input logic [3:0] er, input logic ei, input int s);
      vec_t v;
      v.rst_n = r; v.mon = mon; v.usel = us; v.dp = dp;
      v.exp_run = er; v.exp_idx = ei; v.scen = s;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   // Drive one cycle of inputs, then compare just after the clock edge.
   task automatic step(input logic r, input logic [3:0] mon, input logic [1:0] us,
                       input logic [3:0] dp, input logic [3:0] er, input logic ei,
                       input int s);
      reset = r; motor_on = mon; USEL = us; disk_present = dp;
      @(posedge clk);
      #1;
      n_vec++;
      if (motor_run !== er || INDEXn !== ei) begin
         n_miss++;
         $display("FAIL %s vec %0d: got motor_run=%b INDEXn=%b, want motor_run=%b INDEXn=%b",
                  scen_name(s), n_vec, motor_run, INDEXn, er, ei);
      end
   endtask

   initial begin
      reset = 1'b0; motor_on = 4'h0; USEL = 2'd0; disk_present = 4'h0;

      // Reset dominates requests; all drives then spin up together.
      add(20, 0, 4'hF, 0, 4'h0, 4'h0, 1, 0);
      add(11, 1, 4'hF, 0, 4'h0, 4'h0, 1, 0);
      add(4,  1, 4'hF, 0, 4'h0, 4'hF, 1, 0);
      // Plain spin-up on drive 0.
      add(1,  0, 4'h0, 0, 4'h0, 4'h0, 1, 1);
      add(11, 1, 4'h1, 0, 4'h0, 4'h0, 1, 1);
      add(2,  1, 4'h1, 0, 4'h0, 4'h1, 1, 1);
      // Drop after the 2nd tick, reassert: full 3 ticks again.
      add(1,  0, 4'h0, 0, 4'h0, 4'h0, 1, 2);
      add(8,  1, 4'h1, 0, 4'h0, 4'h0, 1, 2);
      add(4,  1, 4'h0, 0, 4'h0, 4'h0, 1, 2);
      add(11, 1, 4'h1, 0, 4'h0, 4'h0, 1, 2);
      add(2,  1, 4'h1, 0, 4'h0, 4'h1, 1, 2);
      // Hold on drive 1 expires on the 5th tick after the drop.
      add(1,  0, 4'h0, 0, 4'h0, 4'h0, 1, 3);
      add(11, 1, 4'h2, 0, 4'h0, 4'h0, 1, 3);
      add(1,  1, 4'h2, 0, 4'h0, 4'h2, 1, 3);
      add(19, 1, 4'h0, 0, 4'h0, 4'h2, 1, 3);
      add(2,  1, 4'h0, 0, 4'h0, 4'h0, 1, 3);
      // Reassert at the 4th hold tick; later drop takes a full 5 ticks.
      add(1,  0, 4'h0, 0, 4'h0, 4'h0, 1, 4);
      add(11, 1, 4'h2, 0, 4'h0, 4'h0, 1, 4);
      add(1,  1, 4'h2, 0, 4'h0, 4'h2, 1, 4);
      add(15, 1, 4'h0, 0, 4'h0, 4'h2, 1, 4);
      add(4,  1, 4'h2, 0, 4'h0, 4'h2, 1, 4);
      add(20, 1, 4'h0, 0, 4'h0, 4'h2, 1, 4);
      add(2,  1, 4'h0, 0, 4'h0, 4'h0, 1, 4);
      // Reassert on the very edge that would expire the hold.
      add(1,  0, 4'h0, 0, 4'h0, 4'h0, 1, 5);
      add(11, 1, 4'h2, 0, 4'h0, 4'h0, 1, 5);
      add(1,  1, 4'h2, 0, 4'h0, 4'h2, 1, 5);
      add(19, 1, 4'h0, 0, 4'h0, 4'h2, 1, 5);
      add(4,  1, 4'h2, 0, 4'h0, 4'h2, 1, 5);
      // Index: 8 low / 32 high, disk removal, drive switch and switch back.
      add(1,  0, 4'h1, 0, 4'h1, 4'h0, 1, 6);
      add(11, 1, 4'h1, 0, 4'h1, 4'h0, 1, 6);
      add(1,  1, 4'h1, 0, 4'h1, 4'h1, 1, 6);
      add(8,  1, 4'h1, 0, 4'h1, 4'h1, 0, 6);
      add(32, 1, 4'h1, 0, 4'h1, 4'h1, 1, 6);
      add(8,  1, 4'h1, 0, 4'h1, 4'h1, 0, 6);
      add(4,  1, 4'h1, 0, 4'h1, 4'h1, 1, 6);
      add(10, 1, 4'h1, 0, 4'h0, 4'h1, 1, 6);
      add(1,  1, 4'h1, 0, 4'h1, 4'h1, 0, 6);
      add(6,  1, 4'h1, 2, 4'hF, 4'h1, 1, 6);
      add(1,  1, 4'h1, 0, 4'hF, 4'h1, 1, 6);
      add(2,  1, 4'h1, 0, 4'hF, 4'h1, 0, 6);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].mon, vecs[i].usel, vecs[i].dp,
              vecs[i].exp_run, vecs[i].exp_idx, vecs[i].scen);
      end

      // Drives 0 and 2 staggered by one tick: rise and fall edges 4 clocks apart.
      step(0, 4'h0, 0, 4'h0, 4'h0, 1, 7);
      for (int i = 0; i < 4;  i++) step(1, 4'h1, 0, 4'h0, 4'h0, 1, 7);
      for (int i = 0; i < 7;  i++) step(1, 4'h5, 0, 4'h0, 4'h0, 1, 7);
      for (int i = 0; i < 4;  i++) step(1, 4'h5, 0, 4'h0, 4'h1, 1, 7);
      for (int i = 0; i < 2;  i++) step(1, 4'h5, 0, 4'h0, 4'h5, 1, 7);
      for (int i = 0; i < 4;  i++) step(1, 4'h4, 0, 4'h0, 4'h5, 1, 7);
      for (int i = 0; i < 14; i++) step(1, 4'h0, 0, 4'h0, 4'h5, 1, 7);
      for (int i = 0; i < 4;  i++) step(1, 4'h0, 0, 4'h0, 4'h4, 1, 7);
      for (int i = 0; i < 2;  i++) step(1, 4'h0, 0, 4'h0, 4'h0, 1, 7);

      // Reset in the middle of drive 3 spin-up: no early rise afterwards.
      step(0, 4'h0, 0, 4'h0, 4'h0, 1, 8);
      for (int i = 0; i < 8;  i++) step(1, 4'h8, 0, 4'h0, 4'h0, 1, 8);
      step(0, 4'h8, 0, 4'h0, 4'h0, 1, 8);
      for (int i = 0; i < 11; i++) step(1, 4'h8, 0, 4'h0, 4'h0, 1, 8);
      for (int i = 0; i < 2;  i++) step(1, 4'h8, 0, 4'h0, 4'h8, 1, 8);
      step(0, 4'h8, 0, 4'h0, 4'h0, 1, 8);
      for (int i = 0; i < 16; i++) step(1, 4'h0, 0, 4'h0, 4'h0, 1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
